// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle floating-point multiplier with valid/ready handshakes.
// Datapath: unpack, shift-add mantissa multiply, normalise, round-to-nearest-even.
// Special operands bypass the multiply. Results are flushed to zero instead of subnormal.
module fp_mul_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_ovf,
  output logic                   flag_udf,
  output logic                   flag_inv,
  output logic                   flag_inx
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned CW = $clog2(SW + 1);

  localparam logic signed [EW-1:0] BIAS     = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** EXP_W - 1);
  localparam logic [CW-1:0]        MULT_END = CW'(SW - 1);
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]          a_q, b_q;
  logic                  sign_q;
  logic signed [EW-1:0]  exp_q;
  logic [PW-1:0]         mcand_q;
  logic [SW-1:0]         mplier_q;
  logic [PW-1:0]         prod_q;
  logic [CW-1:0]         cnt_q;

  // ---------------------------------------------------------------------------
  // Unpack view of latched operands
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0]      ea, eb, eeff_a, eeff_b;
  logic [MAN_W-1:0]      fa, fb;
  logic [SW-1:0]         sig_a, sig_b;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                  sign_c;
  logic signed [EW-1:0]  exp_sum_c;
  logic                  special_c;
  logic                  spec_inv_c;
  logic [W-1:0]          spec_res_c;

  // Field decode, effective exponents and special-operand result
  always_comb begin
    ea         = a_q[W-2:MAN_W];
    eb         = b_q[W-2:MAN_W];
    fa         = a_q[MAN_W-1:0];
    fb         = b_q[MAN_W-1:0];
    a_zero     = (ea == '0) && (fa == '0);
    b_zero     = (eb == '0) && (fb == '0);
    a_inf      = (&ea) && (fa == '0);
    b_inf      = (&eb) && (fb == '0);
    a_nan      = (&ea) && (fa != '0);
    b_nan      = (&eb) && (fb != '0);
    sig_a      = {(ea != '0), fa};
    sig_b      = {(eb != '0), fb};
    eeff_a     = (ea == '0) ? EXP_W'(1) : ea;
    eeff_b     = (eb == '0) ? EXP_W'(1) : eb;
    sign_c     = a_q[W-1] ^ b_q[W-1];
    exp_sum_c  = $signed(EW'(eeff_a) + EW'(eeff_b)) - BIAS;
    special_c  = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    spec_inv_c = 1'b0;
    spec_res_c = {sign_c, {(W-1){1'b0}}};
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      spec_res_c = QNAN;
      spec_inv_c = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Normalise / round view of the product
  // ---------------------------------------------------------------------------
  logic                  norm_shl_c;
  logic [SW-1:0]         mant_c, mant_n_c;
  logic [SW:0]           mant_r_c;
  logic                  guard_c, sticky_c, inc_c;
  logic signed [EW-1:0]  exp_n_c;
  logic [W-1:0]          rnd_res_c;
  logic                  rnd_ovf_c, rnd_udf_c, rnd_inx_c;

  // Left-normalise while the leading one is missing and the exponent can drop
  always_comb begin
    norm_shl_c = !prod_q[PW-2] && (exp_q > EXP_ONE);
  end

  // Round-to-nearest-even with overflow to infinity and flush-to-zero
  always_comb begin
    mant_c    = prod_q[PW-2 -: SW];
    guard_c   = prod_q[PW-2-SW];
    sticky_c  = |prod_q[PW-3-SW:0];
    inc_c     = guard_c & (sticky_c | mant_c[0]);
    mant_r_c  = {1'b0, mant_c} + (SW+1)'(inc_c);
    mant_n_c  = mant_r_c[SW] ? mant_r_c[SW:1] : mant_r_c[SW-1:0];
    exp_n_c   = mant_r_c[SW] ? (exp_q + EXP_ONE) : exp_q;
    rnd_inx_c = guard_c | sticky_c;
    rnd_ovf_c = 1'b0;
    rnd_udf_c = 1'b0;
    rnd_res_c = {sign_q, exp_n_c[EXP_W-1:0], mant_n_c[MAN_W-1:0]};
    if (exp_n_c >= EXP_MAX) begin
      rnd_res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_ovf_c = 1'b1;
      rnd_inx_c = 1'b1;
    end else if ((exp_n_c < EXP_ONE) || !mant_n_c[SW-1]) begin
      rnd_res_c = {sign_q, {(W-1){1'b0}}};
      rnd_udf_c = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic accept_c;
  logic take_c;

  // Handshake qualifiers from registered ready/valid
  always_comb begin
    accept_c = in_valid && in_ready;
    take_c   = out_valid && out_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_UNPACK;
      S_UNPACK: state_d = special_c ? S_DONE : S_MULT;
      S_MULT:   if (cnt_q == MULT_END) state_d = S_NORM;
      S_NORM:   if (prod_q[PW-1] || !norm_shl_c) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (take_c) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  // Operand capture, shift-add multiply, normalisation and result/flag update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result   <= '0;
      flag_ovf <= 1'b0;
      flag_udf <= 1'b0;
      flag_inv <= 1'b0;
      flag_inx <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            a_q      <= a;
            b_q      <= b;
            flag_ovf <= 1'b0;
            flag_udf <= 1'b0;
            flag_inv <= 1'b0;
            flag_inx <= 1'b0;
          end
        end
        S_UNPACK: begin
          sign_q   <= sign_c;
          exp_q    <= exp_sum_c;
          mcand_q  <= PW'(sig_a);
          mplier_q <= sig_b;
          prod_q   <= '0;
          cnt_q    <= '0;
          if (special_c) begin
            result   <= spec_res_c;
            flag_inv <= spec_inv_c;
          end
        end
        S_MULT: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_NORM: begin
          if (prod_q[PW-1]) begin
            // Keep the dropped bit as sticky information in bit 0
            prod_q <= {1'b0, prod_q[PW-1:2], prod_q[1] | prod_q[0]};
            exp_q  <= exp_q + EXP_ONE;
          end else if (norm_shl_c) begin
            prod_q <= prod_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end
        end
        S_ROUND: begin
          result   <= rnd_res_c;
          flag_ovf <= rnd_ovf_c;
          flag_udf <= rnd_udf_c;
          flag_inx <= rnd_inx_c;
        end
        default: ;
      endcase
    end
  end

endmodule
